// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade driver.
package led_fade_pkg;

  localparam int NUM_LEDS = 6;

  typedef logic [NUM_LEDS-1:0] led_vec_t;

  // Subtraction that floors at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] value, input logic [31:0] step);
    return (value > step) ? (value - step) : '0;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / LED-out bundle between the wave sequencer and the board pins.
interface led_fade_driver_if;
  import led_fade_pkg::*;

  led_vec_t led_in;
  led_vec_t led_out;
  logic     decay_tick;

  modport master (output led_in, input led_out, input decay_tick);
  modport slave  (input led_in, output led_out, output decay_tick);
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness register with set/decay, optional gamma
// duty stage (LED_FADE_GAMMA_EN), and PWM compare.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                on
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] duty;

  // Input forces full brightness and wins over a coincident decay tick.
  always_comb begin
    bright_d = bright_q;
    if (set) begin
      bright_d = MAX;
    end else if (tick) begin
      bright_d = PWM_BITS'(sat_sub(32'(bright_q), 32'(DECAY_STEP)));
    end
  end

  // Brightness register.
  always_ff @(posedge clk) begin
    if (rst) bright_q <= '0;
    else     bright_q <= bright_d;
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0]   duty_q, duty_d;

  // Quadratic curve: duty = brightness^2 >> PWM_BITS.
  always_comb begin
    prod   = bright_q * bright_q;
    duty_d = PWM_BITS'(prod >> PWM_BITS);
  end

  // Registered duty; the MAX force below hides its extra cycle on turn-on.
  always_ff @(posedge clk) begin
    if (rst) duty_q <= '0;
    else     duty_q <= duty_d;
  end

  assign duty = duty_q;
`else
  assign duty = bright_q;
`endif

  // Full brightness is forced on so there is no one-slot dark gap.
  always_comb begin
    on = (bright_q == MAX) || (pwm_cnt < duty);
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: lights each LED fully while its pattern bit is high,
// then fades it linearly through PWM. Optional gamma curve via the
// LED_FADE_GAMMA_EN macro (see led_fade_channel).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 27000,
  parameter int DECAY_STEP = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  led_fade_driver_if.slave bus
);

  localparam int                PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam led_vec_t          OFF_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  led_vec_t            led_out_q, led_out_d;
  led_vec_t            on_vec;

  // Prescaler wrap, tick pulse, free-running PWM counter, output polarity.
  always_comb begin
    prescaler_d = (prescaler_q == PRE_LAST) ? '0 : prescaler_q + PRE_W'(1);
    tick_d      = (prescaler_q == PRE_LAST);
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    led_out_d   = on_vec ^ OFF_MASK;
  end

  // Shared timing state and registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      tick_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      led_out_q   <= OFF_MASK;
    end else begin
      prescaler_q <= prescaler_d;
      tick_q      <= tick_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_out_q   <= led_out_d;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .set     (bus.led_in[g]),
      .tick    (tick_q),
      .pwm_cnt (pwm_cnt_q),
      .on      (on_vec[g])
    );
  end

  assign bus.led_out    = led_out_q;
  assign bus.decay_tick = tick_q;

endmodule
